// File: rtl/lmdpl_dualrail_unmask.sv
// Receiving end of an LMDPL masked dual-rail link: checks the spacer/codeword protocol, strips the output mask, and hands the result to unmasked logic.
// Optional feature: define LMDPL_FAULT_CNT_EN to add an 8-bit saturating fault_cnt output.
module lmdpl_dualrail_unmask #(
  parameter int WIDTH   = 1,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             precharge,
  input  logic [WIDTH-1:0] q_m,
  input  logic [WIDTH-1:0] q_m_bar,
  input  logic [WIDTH-1:0] m_out,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [1:0]       dbg_state
`ifdef LMDPL_FAULT_CNT_EN
  ,
  output logic [7:0]       fault_cnt
`endif
);

  // Handshake: a result transfers on any rising edge where out_valid && out_ready;
  // out and out_valid never change while out_valid=1 and out_ready=0.

  typedef enum logic [1:0] {
    S_PRE  = 2'd0,
    S_EVAL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int            CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  localparam logic [2:0] E_SPACER_MISSING  = 3'd1;
  localparam logic [2:0] E_DUAL_RAIL       = 3'd2;
  localparam logic [2:0] E_TIMEOUT         = 3'd3;
  localparam logic [2:0] E_EARLY_PRECHARGE = 3'd4;
  localparam logic [2:0] E_OVERRUN         = 3'd5;

  state_t           r_state, w_state_nxt;
  logic             r_spacer_seen, w_spacer_seen_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_mask_q, w_mask_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_err, w_err_nxt;
  logic [2:0]       r_err_code, w_err_code_nxt;
  logic             r_prev_pre;

  logic w_spacer, w_complete, w_dual;

  assign w_spacer   = ~|(q_m | q_m_bar);
  assign w_complete = &(q_m ^ q_m_bar);
  assign w_dual     = |(q_m & q_m_bar);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_PRE;
      r_spacer_seen <= 1'b0;
      r_cnt         <= '0;
      r_mask_q      <= '0;
      r_out         <= '0;
      r_out_valid   <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= 3'd0;
      r_prev_pre    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_spacer_seen <= w_spacer_seen_nxt;
      r_cnt         <= w_cnt_nxt;
      r_mask_q      <= w_mask_nxt;
      r_out         <= w_out_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_err         <= w_err_nxt;
      r_err_code    <= w_err_code_nxt;
      r_prev_pre    <= precharge;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_spacer_seen_nxt = r_spacer_seen;
    w_cnt_nxt         = r_cnt;
    w_mask_nxt        = r_mask_q;
    w_out_nxt         = r_out;
    w_out_valid_nxt   = r_out_valid;
    w_err_nxt         = 1'b0;
    w_err_code_nxt    = r_err_code;
    case (r_state)
      S_PRE: begin
        if (precharge) begin
          if (w_spacer) w_spacer_seen_nxt = 1'b1;
        end else if (r_spacer_seen) begin
          // Mask is captured only here so mid-evaluation m_out changes cannot leak in.
          w_mask_nxt        = m_out;
          w_cnt_nxt         = '0;
          w_spacer_seen_nxt = 1'b0;
          w_state_nxt       = S_EVAL;
        end else begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = E_SPACER_MISSING;
        end
      end
      S_EVAL: begin
        if (precharge) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = E_EARLY_PRECHARGE;
          w_state_nxt    = S_PRE;
        end else if (w_dual) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = E_DUAL_RAIL;
          w_state_nxt    = S_PRE;
        end else if (w_complete) begin
          w_out_nxt       = q_m ^ r_mask_q;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_HOLD;
        end else if (r_cnt == CNT_MAX) begin
          w_err_nxt      = 1'b1;
          w_err_code_nxt = E_TIMEOUT;
          w_state_nxt    = S_PRE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_HOLD: begin
        if (precharge && w_spacer) w_spacer_seen_nxt = 1'b1;
        // A new evaluation started while a result is still parked: drop it, keep the held data.
        if (r_prev_pre && !precharge) begin
          w_err_nxt         = 1'b1;
          w_err_code_nxt    = E_OVERRUN;
          w_spacer_seen_nxt = 1'b0;
        end
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_PRE;
        end
      end
      default: w_state_nxt = S_PRE;
    endcase
  end

`ifdef LMDPL_FAULT_CNT_EN
  logic [7:0] r_fault_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault_cnt <= 8'd0;
    end else if (w_err_nxt && (r_fault_cnt != 8'hFF)) begin
      r_fault_cnt <= r_fault_cnt + 8'd1;
    end
  end

  assign fault_cnt = r_fault_cnt;
`endif

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lmdpl_dualrail_unmask.sv
// Directed bench for lmdpl_dualrail_unmask (WIDTH=2, TIMEOUT=4); one task per scenario with inline checks.
module tb_lmdpl_dualrail_unmask;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         precharge;
  logic [W-1:0] q_m, q_m_bar, m_out;
  logic [W-1:0] out;
  logic         out_valid, out_ready, err;
  logic [2:0]   err_code;
  logic [1:0]   dbg_state;
`ifdef LMDPL_FAULT_CNT_EN
  logic [7:0]   fault_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  lmdpl_dualrail_unmask #(.WIDTH(W), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .precharge(precharge),
    .q_m(q_m), .q_m_bar(q_m_bar), .m_out(m_out),
    .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .err_code(err_code), .dbg_state(dbg_state)
`ifdef LMDPL_FAULT_CNT_EN
    , .fault_cnt(fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rails(input logic pre, input logic [W-1:0] t, input logic [W-1:0] f);
    precharge = pre;
    q_m       = t;
    q_m_bar   = f;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; m_out = '0;
    rails(1'b1, 2'b00, 2'b00);
    tick(); tick();
    rst = 1'b0;
    if (out !== 2'b00)      begin $display("FAIL reset_out: got %0h exp 0", out); n_miss++; end n_vec++;
    if (out_valid !== 1'b0) begin $display("FAIL reset_valid: got %0b exp 0", out_valid); n_miss++; end n_vec++;
    if (err !== 1'b0)       begin $display("FAIL reset_err: got %0b exp 0", err); n_miss++; end n_vec++;
    if (err_code !== 3'd0)  begin $display("FAIL reset_code: got %0d exp 0", err_code); n_miss++; end n_vec++;
    if (dbg_state !== 2'd0) begin $display("FAIL reset_state: got %0d exp 0", dbg_state); n_miss++; end n_vec++;
  endtask

  task automatic test_nominal();
    tick();                                   // spacer seen
    precharge = 1'b0; m_out = 2'b11;
    tick();                                   // enter evaluate, mask=11
    if (dbg_state !== 2'd1) begin $display("FAIL nom_eval_state: got %0d exp 1", dbg_state); n_miss++; end n_vec++;
    if (out_valid !== 1'b0) begin $display("FAIL nom_early_valid: got %0b exp 0", out_valid); n_miss++; end n_vec++;
    m_out = 2'b00;                            // must be ignored
    rails(1'b0, 2'b01, 2'b10);
    tick();
    if (out_valid !== 1'b1) begin $display("FAIL nom_valid: got %0b exp 1", out_valid); n_miss++; end n_vec++;
    if (out !== 2'b10)      begin $display("FAIL nom_out: got %0h exp 2", out); n_miss++; end n_vec++;
    if (err !== 1'b0)       begin $display("FAIL nom_err: got %0b exp 0", err); n_miss++; end n_vec++;
    if (dbg_state !== 2'd2) begin $display("FAIL nom_hold_state: got %0d exp 2", dbg_state); n_miss++; end n_vec++;
    rails(1'b1, 2'b00, 2'b00); out_ready = 1'b1;
    tick();
    if (out_valid !== 1'b0) begin $display("FAIL nom_xfer_valid: got %0b exp 0", out_valid); n_miss++; end n_vec++;
    if (dbg_state !== 2'd0) begin $display("FAIL nom_xfer_state: got %0d exp 0", dbg_state); n_miss++; end n_vec++;
    if (err !== 1'b0)       begin $display("FAIL nom_xfer_err: got %0b exp 0", err); n_miss++; end n_vec++;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    precharge = 1'b0; m_out = 2'b01;
    tick();
    rails(1'b0, 2'b10, 2'b00);                // only one pair resolved
    tick();
    if (out_valid !== 1'b0) begin $display("FAIL bp_partial_valid: got %0b exp 0", out_valid); n_miss++; end n_vec++;
    if (dbg_state !== 2'd1) begin $display("FAIL bp_partial_state: got %0d exp 1", dbg_state); n_miss++; end n_vec++;
    rails(1'b0, 2'b10, 2'b01);
    tick();
    rails(1'b1, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b1) begin $display("FAIL bp_hold_valid[%0d]: got %0b exp 1", i, out_valid); n_miss++; end n_vec++;
      if (out !== 2'b11)      begin $display("FAIL bp_hold_out[%0d]: got %0h exp 3", i, out); n_miss++; end n_vec++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    if (out_valid !== 1'b0) begin $display("FAIL bp_xfer_valid: got %0b exp 0", out_valid); n_miss++; end n_vec++;
    if (dbg_state !== 2'd0) begin $display("FAIL bp_xfer_state: got %0d exp 0", dbg_state); n_miss++; end n_vec++;
    if (err !== 1'b0)       begin $display("FAIL bp_err: got %0b exp 0", err); n_miss++; end n_vec++;
    out_ready = 1'b0;
  endtask

  task automatic test_dual_rail();
    precharge = 1'b0; m_out = 2'b00;
    tick();
    rails(1'b0, 2'b01, 2'b01);
    tick();
    if (err !== 1'b1)       begin $display("FAIL dual_err: got %0b exp 1", err); n_miss++; end n_vec++;
    if (err_code !== 3'd2)  begin $display("FAIL dual_code: got %0d exp 2", err_code); n_miss++; end n_vec++;
    if (out_valid !== 1'b0) begin $display("FAIL dual_valid: got %0b exp 0", out_valid); n_miss++; end n_vec++;
    if (dbg_state !== 2'd0) begin $display("FAIL dual_state: got %0d exp 0", dbg_state); n_miss++; end n_vec++;
    rails(1'b1, 2'b00, 2'b00);
    tick();
    if (err !== 1'b0)       begin $display("FAIL dual_pulse: got %0b exp 0", err); n_miss++; end n_vec++;
    precharge = 1'b0; m_out = 2'b10;
    tick();
    rails(1'b0, 2'b00, 2'b11);
    tick();
    if (out_valid !== 1'b1) begin $display("FAIL dual_rec_valid: got %0b exp 1", out_valid); n_miss++; end n_vec++;
    if (out !== 2'b10)      begin $display("FAIL dual_rec_out: got %0h exp 2", out); n_miss++; end n_vec++;
    if (err_code !== 3'd2)  begin $display("FAIL dual_code_held: got %0d exp 2", err_code); n_miss++; end n_vec++;
    rails(1'b1, 2'b00, 2'b00); out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    precharge = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (err !== 1'b0 || dbg_state !== 2'd1) begin
        $display("FAIL tmo_wait[%0d]: got err=%0b state=%0d exp err=0 state=1", i, err, dbg_state); n_miss++;
      end
      n_vec++;
    end
    tick();
    if (err !== 1'b1)       begin $display("FAIL tmo_err: got %0b exp 1", err); n_miss++; end n_vec++;
    if (err_code !== 3'd3)  begin $display("FAIL tmo_code: got %0d exp 3", err_code); n_miss++; end n_vec++;
    if (dbg_state !== 2'd0) begin $display("FAIL tmo_state: got %0d exp 0", dbg_state); n_miss++; end n_vec++;
  endtask

  task automatic test_missing_spacer();
    rails(1'b1, 2'b01, 2'b00);
    tick();
    precharge = 1'b0;
    tick();
    if (err !== 1'b1)       begin $display("FAIL nosp_err: got %0b exp 1", err); n_miss++; end n_vec++;
    if (err_code !== 3'd1)  begin $display("FAIL nosp_code: got %0d exp 1", err_code); n_miss++; end n_vec++;
    if (dbg_state !== 2'd0) begin $display("FAIL nosp_state: got %0d exp 0", dbg_state); n_miss++; end n_vec++;
    rails(1'b1, 2'b00, 2'b00);
    tick();
    precharge = 1'b0;
    tick();
    precharge = 1'b1;
    tick();
    if (err !== 1'b1)       begin $display("FAIL early_err: got %0b exp 1", err); n_miss++; end n_vec++;
    if (err_code !== 3'd4)  begin $display("FAIL early_code: got %0d exp 4", err_code); n_miss++; end n_vec++;
    if (dbg_state !== 2'd0) begin $display("FAIL early_state: got %0d exp 0", dbg_state); n_miss++; end n_vec++;
  endtask

  task automatic test_overrun();
    tick();                                   // spacer seen
    precharge = 1'b0; m_out = 2'b00;
    tick();
    rails(1'b0, 2'b11, 2'b00);
    tick();
    rails(1'b1, 2'b00, 2'b00);
    tick();
    precharge = 1'b0;
    tick();
    if (err !== 1'b1)       begin $display("FAIL ovr_err: got %0b exp 1", err); n_miss++; end n_vec++;
    if (err_code !== 3'd5)  begin $display("FAIL ovr_code: got %0d exp 5", err_code); n_miss++; end n_vec++;
    if (out_valid !== 1'b1 || out !== 2'b11) begin
      $display("FAIL ovr_held: got valid=%0b out=%0h exp valid=1 out=3", out_valid, out); n_miss++;
    end
    n_vec++;
    precharge = 1'b1;
    tick();
    precharge = 1'b0; out_ready = 1'b1;
    tick();
    if (err !== 1'b1 || err_code !== 3'd5) begin
      $display("FAIL ovr_xfer_err: got err=%0b code=%0d exp err=1 code=5", err, err_code); n_miss++;
    end
    n_vec++;
    if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL ovr_xfer: got valid=%0b state=%0d exp valid=0 state=0", out_valid, dbg_state); n_miss++;
    end
    n_vec++;
    out_ready = 1'b0;
    rails(1'b1, 2'b00, 2'b00);
    tick();
  endtask

  task automatic test_reset_mid_hold();
    precharge = 1'b0; m_out = 2'b00;
    tick();
    rails(1'b0, 2'b01, 2'b10);
    tick();
    if (out_valid !== 1'b1 || out !== 2'b01) begin
      $display("FAIL rmh_setup: got valid=%0b out=%0h exp valid=1 out=1", out_valid, out); n_miss++;
    end
    n_vec++;
    rails(1'b1, 2'b00, 2'b00); rst = 1'b1;
    tick();
    rst = 1'b0;
    if (out_valid !== 1'b0) begin $display("FAIL rmh_valid: got %0b exp 0", out_valid); n_miss++; end n_vec++;
    if (out !== 2'b00)      begin $display("FAIL rmh_out: got %0h exp 0", out); n_miss++; end n_vec++;
    if (err_code !== 3'd0)  begin $display("FAIL rmh_code: got %0d exp 0", err_code); n_miss++; end n_vec++;
    if (dbg_state !== 2'd0) begin $display("FAIL rmh_state: got %0d exp 0", dbg_state); n_miss++; end n_vec++;
  endtask

`ifdef LMDPL_FAULT_CNT_EN
  task automatic test_fault_cnt();
    rst = 1'b1; rails(1'b1, 2'b00, 2'b00);
    tick();
    rst = 1'b0;
    if (fault_cnt !== 8'd0) begin $display("FAIL fcnt_reset: got %0d exp 0", fault_cnt); n_miss++; end n_vec++;
    precharge = 1'b0;                         // no spacer seen: one fault per cycle
    for (int i = 0; i < 3; i++) tick();
    if (fault_cnt !== 8'd3) begin $display("FAIL fcnt_3: got %0d exp 3", fault_cnt); n_miss++; end n_vec++;
    for (int i = 0; i < 297; i++) tick();
    if (fault_cnt !== 8'd255) begin $display("FAIL fcnt_sat: got %0d exp 255", fault_cnt); n_miss++; end n_vec++;
    precharge = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_dual_rail();
    test_timeout();
    test_missing_spacer();
    test_overrun();
    test_reset_mid_hold();
`ifdef LMDPL_FAULT_CNT_EN
    test_fault_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
